// File: rtl/uart_tx_ctrl.sv
// UART TX sequencer: one-entry holding buffer, programmable bit period, TX status writeback.
// Optional parity bit generation is compiled in when UART_TX_PARITY_EN is defined.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] ctrl_reg_i,
  input  logic [DATA_WIDTH-1:0] tx_reg_i,
  input  logic                  tx_wr_i,
  input  logic [DATA_WIDTH-1:0] stat_reg_i,
  output logic [DATA_WIDTH-1:0] stat_data_o,
  output logic                  stat_wr_en_o,
  output logic                  uart_tx_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  state_t                 state_q, state_d;
  logic [DIV_WIDTH-1:0]   baud_q, div_q;
  logic [2:0]             bit_q;
  logic [7:0]             sh_q, buf_q;
  logic                   buf_vld_q;
  logic                   two_stop_q;
`ifdef UART_TX_PARITY_EN
  logic                   par_en_q, par_bit_q;
`endif

  logic                   tx_en, wr_acc, bit_end, last_stop, frame_end;
  logic                   chain, start_frame, overrun;
  logic [7:0]             start_byte;
  logic [DIV_WIDTH-1:0]   ctrl_div;
  logic                   line_d, busy_d, stat_wr_d;
  logic [DATA_WIDTH-1:0]  stat_dat_d;

  assign tx_en       = ctrl_reg_i[0];
  assign ctrl_div    = ctrl_reg_i[16 +: DIV_WIDTH];
  assign wr_acc      = tx_wr_i & tx_en;
  assign bit_end     = (state_q != S_IDLE) && (baud_q == '0);
  assign last_stop   = (state_q == S_STOP2) || ((state_q == S_STOP1) && !two_stop_q);
  assign frame_end   = bit_end && last_stop;
  // A write landing on frame end with an empty buffer chains straight into the next frame.
  assign chain       = frame_end && ((buf_vld_q && tx_en) || wr_acc);
  assign start_frame = ((state_q == S_IDLE) && wr_acc) || chain;
  assign start_byte  = ((state_q != S_IDLE) && buf_vld_q) ? buf_q : tx_reg_i[7:0];
  assign overrun     = wr_acc && (state_q != S_IDLE) && !frame_end && buf_vld_q;

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      uart_tx_o    <= 1'b1;
      busy_o       <= 1'b0;
      stat_wr_en_o <= 1'b0;
      stat_data_o  <= '0;
    end else begin
      state_q      <= state_d;
      uart_tx_o    <= line_d;
      busy_o       <= busy_d;
      stat_wr_en_o <= stat_wr_d;
      stat_data_o  <= stat_dat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (wr_acc) state_d = S_START;
      S_START:  if (bit_end) state_d = S_DATA;
      S_DATA:
        if (bit_end && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_en_q ? S_PARITY : S_STOP1;
`else
          state_d = S_STOP1;
`endif
        end
      S_PARITY: if (bit_end) state_d = S_STOP1;
      S_STOP1:
        if (bit_end) begin
          if (two_stop_q) state_d = S_STOP2;
          else            state_d = chain ? S_START : S_IDLE;
        end
      S_STOP2:  if (bit_end) state_d = chain ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != S_IDLE);
    line_d = 1'b1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = ((state_q == S_DATA) && bit_end) ? sh_q[1] : sh_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = par_bit_q;
`endif
      default:  line_d = 1'b1;
    endcase
    stat_wr_d  = start_frame || frame_end || overrun;
    stat_dat_d = {stat_reg_i[DATA_WIDTH-1:3], stat_reg_i[2] | overrun, busy_d,
                  stat_reg_i[0] | frame_end};
  end

  // Shifter, baud counter and per-frame configuration
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      baud_q     <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      two_stop_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (start_frame) begin
      baud_q     <= ctrl_div;
      div_q      <= ctrl_div;
      bit_q      <= '0;
      sh_q       <= start_byte;
      two_stop_q <= ctrl_reg_i[3];
`ifdef UART_TX_PARITY_EN
      par_en_q   <= ctrl_reg_i[1];
      par_bit_q  <= (^start_byte) ^ ctrl_reg_i[2];
`endif
    end else if (bit_end) begin
      baud_q <= div_q;
      if (state_q == S_DATA) begin
        sh_q  <= {1'b0, sh_q[7:1]};
        bit_q <= bit_q + 3'd1;
      end
    end else if (state_q != S_IDLE) begin
      baud_q <= baud_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      buf_vld_q <= 1'b0;
      buf_q     <= '0;
    end else if (state_q != S_IDLE) begin
      if (frame_end) begin
        // Buffer drains on chaining; refilled only when a write coincides with it.
        buf_vld_q <= buf_vld_q && tx_en && wr_acc;
        if (buf_vld_q && wr_acc) buf_q <= tx_reg_i[7:0];
      end else if (wr_acc && !buf_vld_q) begin
        buf_vld_q <= 1'b1;
        buf_q     <= tx_reg_i[7:0];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl against a frame-level reference model.
module tb_uart_tx_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] ctrl_reg_i, tx_reg_i, stat_reg_i;
  logic        tx_wr_i;
  logic [31:0] stat_data_o;
  logic        stat_wr_en_o, uart_tx_o, busy_o;

  uart_tx_ctrl #(.DATA_WIDTH(32), .DIV_WIDTH(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .ctrl_reg_i(ctrl_reg_i), .tx_reg_i(tx_reg_i),
    .tx_wr_i(tx_wr_i), .stat_reg_i(stat_reg_i), .stat_data_o(stat_data_o),
    .stat_wr_en_o(stat_wr_en_o), .uart_tx_o(uart_tx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a list of line levels, each held for m_per cycles.
  bit          m_act;
  bit          m_bits[12];
  int          m_n, m_per, m_pos;
  logic [7:0]  m_buf[$];
  bit          e_wr;
  logic [31:0] e_dat;

  task automatic m_start(input logic [7:0] b);
    m_per = int'(ctrl_reg_i[31:16]) + 1;
    m_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) m_bits[1+i] = b[i];
    m_n = 9;
`ifdef UART_TX_PARITY_EN
    if (ctrl_reg_i[1]) begin
      m_bits[m_n] = (^b) ^ ctrl_reg_i[2];
      m_n++;
    end
`endif
    m_bits[m_n] = 1'b1;
    m_n++;
    if (ctrl_reg_i[3]) begin
      m_bits[m_n] = 1'b1;
      m_n++;
    end
    m_pos = 0;
    m_act = 1'b1;
  endtask

  task automatic m_step();
    bit en, wr, fend, ovr;
    en   = ctrl_reg_i[0];
    wr   = tx_wr_i && en;
    fend = m_act && (m_pos == m_n * m_per - 1);
    ovr  = 1'b0;
    e_wr = 1'b0;
    if (!m_act) begin
      if (wr) begin
        m_start(tx_reg_i[7:0]);
        e_wr = 1'b1;
      end
    end else if (fend) begin
      e_wr = 1'b1;
      if (m_buf.size() > 0 && en) begin
        m_start(m_buf.pop_front());
        if (wr) m_buf.push_back(tx_reg_i[7:0]);
      end else if (m_buf.size() > 0) begin
        m_buf.delete();
        m_act = 1'b0;
      end else if (wr) begin
        m_start(tx_reg_i[7:0]);
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_pos++;
      if (wr) begin
        if (m_buf.size() > 0) begin
          ovr  = 1'b1;
          e_wr = 1'b1;
        end else begin
          m_buf.push_back(tx_reg_i[7:0]);
        end
      end
    end
    e_dat = {stat_reg_i[31:3], stat_reg_i[2] | ovr, m_act, stat_reg_i[0] | fend};
  endtask

  task automatic cyc(input logic wr, input logic [7:0] d);
    logic exp_line;
    @(negedge clk_i);
    tx_wr_i       = wr;
    tx_reg_i      = $urandom();
    tx_reg_i[7:0] = d;
    stat_reg_i    = $urandom();
    if ($urandom_range(3) != 0) stat_reg_i[2:0] = 3'b000;
    @(posedge clk_i);
    m_step();
    #1;
    exp_line = m_act ? m_bits[m_pos / m_per] : 1'b1;
    chk("line", uart_tx_o, exp_line);
    chk("busy", busy_o, m_act);
    chk("stat_wr", stat_wr_en_o, e_wr);
    if (e_wr) chk("stat_data", stat_data_o, e_dat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  function automatic logic [31:0] mk_ctrl(input int div, input logic [3:0] f);
    logic [31:0] c;
    c = '0;
    c[31:16] = div[15:0];
    c[3:0]   = f;
    return c;
  endfunction

  int cnt;

  initial begin
    rstn_i = 1'b0; tx_wr_i = 1'b0; tx_reg_i = '0; stat_reg_i = '0; ctrl_reg_i = '0;
    m_act = 1'b0; m_n = 10; m_per = 1; m_pos = 0;
    #12;
    chk("rst_line", uart_tx_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wr", stat_wr_en_o, 1'b0);
    chk("rst_data", stat_data_o, 32'h0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle(3);

    // 8N1, DIV=3, 0x55: 40 busy cycles
    ctrl_reg_i = mk_ctrl(3, 4'b0001);
    cyc(1'b1, 8'h55);
    cnt = busy_o;
    for (int i = 0; i < 44; i++) begin
      cyc(1'b0, 8'h00);
      cnt += busy_o;
    end
    chk("len_8n1", cnt, 40);

    // Back-to-back: one idle (busy=0) status write after the second frame
    cyc(1'b1, 8'hA5);
    idle(5);
    cyc(1'b1, 8'h3C);
    cnt = 0;
    for (int i = 0; i < 90; i++) begin
      cyc(1'b0, 8'h00);
      if (stat_wr_en_o && !stat_data_o[1]) cnt++;
    end
    chk("b2b_end_writes", cnt, 1);

    // Overrun with DIV=1
    ctrl_reg_i = mk_ctrl(1, 4'b0001);
    cyc(1'b1, 8'h11); cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h22); cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h33);
    idle(60);

    // Disable mid-frame with a buffered byte: only one 20-cycle frame
    cyc(1'b1, 8'h81);
    cnt = busy_o;
    cyc(1'b1, 8'h42);
    cnt += busy_o;
    for (int i = 0; i < 35; i++) begin
      if (i == 5) ctrl_reg_i = mk_ctrl(1, 4'b0000);
      cyc(1'b0, 8'h00);
      cnt += busy_o;
    end
    chk("dis_len", cnt, 20);

    // Odd parity, two stop bits, byte 0x07
    ctrl_reg_i = mk_ctrl(1, 4'b1111);
    cyc(1'b1, 8'h07);
    cnt = busy_o;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, 8'h00);
      cnt += busy_o;
    end
`ifdef UART_TX_PARITY_EN
    chk("len_par2", cnt, 24);
`else
    chk("len_par2", cnt, 22);
`endif

    // Reset mid-frame
    ctrl_reg_i = mk_ctrl(2, 4'b0001);
    cyc(1'b1, 8'h00);
    idle(7);
    @(negedge clk_i);
    rstn_i = 1'b0; tx_wr_i = 1'b0;
    #1;
    chk("mid_rst_line", uart_tx_o, 1'b1);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_wr", stat_wr_en_o, 1'b0);
    m_act = 1'b0;
    m_buf.delete();
    @(negedge clk_i);
    rstn_i = 1'b1;
    idle(2);

    // Random traffic with occasional control changes
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) begin
        ctrl_reg_i = mk_ctrl($urandom_range(3), {$urandom_range(7), 1'b0} | 4'($urandom_range(9) != 0));
      end
      cyc($urandom_range(11) == 0, 8'($urandom()));
    end
    ctrl_reg_i = mk_ctrl(0, 4'b0000);
    idle(60);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
